// File: rtl/parity_check_buffer.sv
// parity_check_buffer: registered parity checker feeding a small
// first-word-fall-through FIFO. Each accepted beat is stored with its
// parity verdict; a saturating counter tallies bad beats.
// Optional build macro: PARITY_DROP_BAD_EN. When defined, bad beats are
// still handshaken and counted but are not written into the buffer.
module parity_check_buffer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 2,
   parameter int PARITY_ODD = 0,
   parameter int CNT_W      = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              PARITY_CHECK_BIT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              DATA_VALID,
   output logic              REG_FULL,
   output logic [CNT_W-1:0]  ERR_COUNT,
   input  logic              CLR_ERR
);

   localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic        C_ODD  = (PARITY_ODD != 0);

   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic [CNT_W-1:0]  r_err;

   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_good;
   logic w_write;

   assign w_full = (r_count == C_FULL);
   assign w_push = IN_VALID && !w_full;
   assign w_pop  = OUT_VALID && OUT_READY;
   assign w_good = ~(^DATA_IN ^ PARITY_CHECK_BIT ^ C_ODD);

`ifdef PARITY_DROP_BAD_EN
   // Bad beats complete the handshake but never occupy a slot.
   assign w_write = w_push && w_good;
`else
   assign w_write = w_push;
`endif

   assign IN_READY   = !w_full;
   assign REG_FULL   = w_full;
   assign OUT_VALID  = (r_count != '0);
   assign DATA_OUT   = r_data[r_rptr];
   assign DATA_VALID = r_vld[r_rptr];
   assign ERR_COUNT  = r_err;

   // Buffer storage, pointers and occupancy; storage is cleared so outputs are never X.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
         r_vld   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_write) begin
            r_data[r_wptr] <= DATA_IN;
            r_vld[r_wptr]  <= w_good;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating count of bad pushes; clear wins over a same-cycle increment.
   always_ff @(posedge CLK) begin
      if (RST || CLR_ERR) begin
         r_err <= '0;
      end else if (w_push && !w_good && (r_err != '1)) begin
         r_err <= r_err + 1'b1;
      end
   end

endmodule

// File: doc/parity_check_buffer.md
Name: parity_check_buffer

Overview:
- Registered, parametrised successor to the combinational parity-valid checker.
- Accepts data beats with an accompanying parity bit over a valid/ready handshake.
- Evaluates even or odd parity and stores each beat with its verdict in a small FIFO, exposing a register-full flag.
- Sits between the I2C byte receiver and downstream consumers; also keeps a saturating parity-error count.

Parameters:
DATA_W, 8, data beat width in bits (>=1)
DEPTH, 2, buffer entries (power of two, >=2)
PARITY_ODD, 0, 0 = beat valid when XOR(data) == parity bit; 1 = valid when XOR(data) != parity bit
CNT_W, 8, error counter width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
IN_VALID  in  1  input beat present
IN_READY  out  1  block can accept a beat
DATA_IN  in  DATA_W  input data
PARITY_CHECK_BIT  in  1  parity bit sent with DATA_IN
OUT_VALID  out  1  head entry available
OUT_READY  in  1  consumer takes head entry
DATA_OUT  out  DATA_W  head entry data
DATA_VALID  out  1  head entry parity verdict (1 = good)
REG_FULL  out  1  buffer holds DEPTH entries
ERR_COUNT  out  CNT_W  saturating count of failed beats
CLR_ERR  in  1  synchronous clear of ERR_COUNT

Behaviour:
- One clock (CLK); reset RST is synchronous and active-high.
- Reset values: OUT_VALID=0, REG_FULL=0, IN_READY=1, DATA_OUT=0, DATA_VALID=0, ERR_COUNT=0; read pointer, write pointer and occupancy are 0.
- Reset asserted mid-transfer discards all buffered entries; no beat is accepted in the reset cycle.
- Push: IN_VALID && IN_READY at a rising edge.
- Pop: OUT_VALID && OUT_READY at a rising edge.
- IN_READY = !REG_FULL, registered-equivalent. No pass-through when full: a push is refused even if a pop occurs in the same cycle.
- Verdict is computed from DATA_IN and PARITY_CHECK_BIT at push time: good = (^DATA_IN ^ PARITY_CHECK_BIT ^ PARITY_ODD) == 0. The verdict is stored with the data.
- Latency: a beat pushed at edge N shows OUT_VALID=1 with its DATA_OUT/DATA_VALID after edge N (first-word-fall-through from registered storage, one cycle).
- DATA_OUT/DATA_VALID hold stable while OUT_VALID=1 and OUT_READY=0. Values are don't-care when OUT_VALID=0, but must not be X after reset.
- Occupancy:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, pointers both advance
  - pop when empty: impossible (OUT_VALID=0)
- REG_FULL = (occupancy == DEPTH). OUT_VALID = (occupancy != 0).
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- ERR_COUNT increments by 1 on each push whose verdict is bad. It saturates at 2^CNT_W-1 with no wrap.
- CLR_ERR has priority: if CLR_ERR=1, ERR_COUNT becomes 0 next cycle, even when a bad beat is pushed in the same cycle.
- Error counting is independent of pops.

Optional Feature:
- Macro: PARITY_DROP_BAD_EN.
- Defined:
  - Bad-parity beats are still handshaken (IN_READY semantics unchanged) and counted in ERR_COUNT.
  - They are not written into the buffer, so occupancy is unchanged by them.
  - DATA_VALID is therefore always 1 whenever OUT_VALID=1.
- Undefined: all beats are buffered with their verdict as described above.

Test Plan:
- Reset, then DATA_IN=0xA5, PARITY_CHECK_BIT=0, PARITY_ODD=0, one push -> next cycle OUT_VALID=1, DATA_OUT=0xA5, DATA_VALID=1, ERR_COUNT=0.
- Push DATA_IN=0x07 with parity 0 (even) -> DATA_VALID=0, ERR_COUNT=1. Same beat with PARITY_ODD=1 -> DATA_VALID=1, ERR_COUNT=0. With PARITY_DROP_BAD_EN defined, the even-parity case -> OUT_VALID stays 0, ERR_COUNT=1.
- OUT_READY=0, push 0x11 then 0x22 (DEPTH=2) -> REG_FULL=1, IN_READY=0. A third IN_VALID with 0x33 is held off. Raise OUT_READY -> outputs 0x11, 0x22, then 0x33 after acceptance, in order.
- Full buffer, IN_VALID=1 and OUT_READY=1 in the same cycle -> pop only, no push that cycle; push on the next edge. Steady push+pop at half occupancy over 10 beats -> occupancy constant, pointers wrap, data order preserved.
- CNT_W=2, push 4 bad beats -> ERR_COUNT sequence 1,2,3,3. Then CLR_ERR=1 together with a bad push -> ERR_COUNT=0.
- Buffer holding 2 entries, assert RST for one cycle with IN_VALID=1 -> OUT_VALID=0, REG_FULL=0, ERR_COUNT=0, no entry retained.
